// File: rtl/salamander_sram_dp.sv
// Dual-port synchronous SRAM: port A read/write with byte lanes, port B read-only,
// selectable read latency and read-during-write behaviour, plus a constant-fill clear sweep.
module salamander_sram_dp #(
    parameter int             AW         = 10,
    parameter int             DW         = 16,
    parameter int             RDLAT      = 1,
    parameter int             RDW_MODE   = 0,
    parameter int             CLR_ON_RST = 1,
    parameter logic [DW-1:0]  CLR_VAL    = {DW{1'b0}}
) (
    input  logic              i_MCLK,
    input  logic              i_RST_n,
    input  logic              i_CLR,
    output logic              o_BUSY,
    input  logic [AW-1:0]     i_A_ADDR,
    input  logic [DW-1:0]     i_A_DIN,
    input  logic [DW/8-1:0]   i_A_BE,
    input  logic              i_A_WR,
    input  logic              i_A_RD,
    output logic [DW-1:0]     o_A_DOUT,
    output logic              o_A_VALID,
    input  logic [AW-1:0]     i_B_ADDR,
    input  logic              i_B_RD,
    output logic [DW-1:0]     o_B_DOUT,
    output logic              o_B_VALID
);
    localparam int NBE = DW / 8;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam state_t S_RST = (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_cnt;
    logic              r_busy;
    logic [DW-1:0]     r_mem [0:(2**AW)-1];

    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [DW-1:0]     w_wdata;
    logic [NBE-1:0]    w_wbe;
    logic              w_a_rd;
    logic              w_b_rd;
    logic [DW-1:0]     w_a_rdata;
    logic [DW-1:0]     w_b_old;
    logic [DW-1:0]     w_b_rdata;
    logic              w_b_hit;

    logic              r_a_s1_v;
    logic [DW-1:0]     r_a_s1_d;
    logic              r_b_s1_v;
    logic [DW-1:0]     r_b_s1_d;

    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] i_old,
                                              input logic [DW-1:0] i_new,
                                              input logic [NBE-1:0] i_be);
        logic [DW-1:0] v;
        v = i_old;
        for (int n = 0; n < NBE; n++) begin
            if (i_be[n]) begin
                v[8*n +: 8] = i_new[8*n +: 8];
            end
        end
        return v;
    endfunction

    // State, sweep counter and busy flag; busy follows the state being entered
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_state <= S_RST;
            r_cnt   <= {AW{1'b0}};
            r_busy  <= (S_RST == S_CLEAR);
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_CLEAR);
            if (r_state == S_CLEAR) begin
                r_cnt <= r_cnt + AW'(1'b1);
            end else begin
                r_cnt <= {AW{1'b0}};
            end
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_CLR) begin
                    w_state_nxt = S_CLEAR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (&r_cnt) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_CLEAR;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Port/sweep arbitration: the sweep owns the write port, reads are gated off
    always_comb begin
        w_we    = 1'b0;
        w_waddr = i_A_ADDR;
        w_wdata = i_A_DIN;
        w_wbe   = i_A_BE;
        w_a_rd  = 1'b0;
        w_b_rd  = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
                w_wdata = CLR_VAL;
                w_wbe   = {NBE{1'b1}};
            end
            S_IDLE: begin
                w_we   = i_A_WR;
                w_a_rd = i_A_RD & ~i_A_WR;
                w_b_rd = i_B_RD;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    assign o_BUSY    = r_busy;
    assign w_a_rdata = r_mem[i_A_ADDR];
    assign w_b_old   = r_mem[i_B_ADDR];
    assign w_b_hit   = (RDW_MODE != 0) && i_A_WR && (i_A_ADDR == i_B_ADDR);
    assign w_b_rdata = w_b_hit ? f_merge(w_b_old, i_A_DIN, i_A_BE) : w_b_old;

    // Storage array, byte-lane writes, never reset
    always_ff @(posedge i_MCLK) begin
        for (int n = 0; n < NBE; n++) begin
            if (w_we && w_wbe[n]) begin
                r_mem[w_waddr][8*n +: 8] <= w_wdata[8*n +: 8];
            end
        end
    end

    // First read stage: data holds when no read is issued
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_a_s1_v <= 1'b0;
            r_a_s1_d <= {DW{1'b0}};
            r_b_s1_v <= 1'b0;
            r_b_s1_d <= {DW{1'b0}};
        end else begin
            r_a_s1_v <= w_a_rd;
            r_b_s1_v <= w_b_rd;
            if (w_a_rd) begin
                r_a_s1_d <= w_a_rdata;
            end
            if (w_b_rd) begin
                r_b_s1_d <= w_b_rdata;
            end
        end
    end

    generate
        if (RDLAT == 2) begin : g_lat2
            // Extra output stage; in-flight reads still drain while a sweep runs
            always_ff @(posedge i_MCLK or negedge i_RST_n) begin
                if (!i_RST_n) begin
                    o_A_VALID <= 1'b0;
                    o_A_DOUT  <= {DW{1'b0}};
                    o_B_VALID <= 1'b0;
                    o_B_DOUT  <= {DW{1'b0}};
                end else begin
                    o_A_VALID <= r_a_s1_v;
                    o_B_VALID <= r_b_s1_v;
                    if (r_a_s1_v) begin
                        o_A_DOUT <= r_a_s1_d;
                    end
                    if (r_b_s1_v) begin
                        o_B_DOUT <= r_b_s1_d;
                    end
                end
            end
        end else begin : g_lat1
            assign o_A_VALID = r_a_s1_v;
            assign o_A_DOUT  = r_a_s1_d;
            assign o_B_VALID = r_b_s1_v;
            assign o_B_DOUT  = r_b_s1_d;
        end
    endgenerate

endmodule

// File: tb/tb_salamander_sram_dp.sv
// Bench for salamander_sram_dp: two instances (latency 1 / old-data RDW, latency 2 / merged RDW)
// share one stimulus stream and are checked every cycle against a word-level model.
module tb_salamander_sram_dp;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [15:0] CV    = 16'hA5A5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic [AW-1:0]    a_addr;
    logic [15:0]      din;
    logic [1:0]       be;
    logic             a_wr;
    logic             a_rd;
    logic [AW-1:0]    b_addr;
    logic             b_rd;

    logic [1:0]       busy;
    logic [1:0]       a_v;
    logic [1:0]       b_v;
    logic [1:0][15:0] a_dout;
    logic [1:0][15:0] b_dout;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    salamander_sram_dp #(.AW(AW), .DW(16), .RDLAT(1), .RDW_MODE(0), .CLR_ON_RST(1), .CLR_VAL(CV)) u_dut0 (
        .i_MCLK(clk), .i_RST_n(rst_n), .i_CLR(clr), .o_BUSY(busy[0]),
        .i_A_ADDR(a_addr), .i_A_DIN(din), .i_A_BE(be), .i_A_WR(a_wr), .i_A_RD(a_rd),
        .o_A_DOUT(a_dout[0]), .o_A_VALID(a_v[0]),
        .i_B_ADDR(b_addr), .i_B_RD(b_rd), .o_B_DOUT(b_dout[0]), .o_B_VALID(b_v[0])
    );

    salamander_sram_dp #(.AW(AW), .DW(16), .RDLAT(2), .RDW_MODE(1), .CLR_ON_RST(1), .CLR_VAL(CV)) u_dut1 (
        .i_MCLK(clk), .i_RST_n(rst_n), .i_CLR(clr), .o_BUSY(busy[1]),
        .i_A_ADDR(a_addr), .i_A_DIN(din), .i_A_BE(be), .i_A_WR(a_wr), .i_A_RD(a_rd),
        .o_A_DOUT(a_dout[1]), .o_A_VALID(a_v[1]),
        .i_B_ADDR(b_addr), .i_B_RD(b_rd), .o_B_DOUT(b_dout[1]), .o_B_VALID(b_v[1])
    );

    // Model: the array contents are shared; only read delivery differs per instance.
    logic [15:0]      m_mem [DEPTH];
    int               m_clr_left;
    int               m_clr_pos;
    logic [1:0]       e_busy, e_av, e_bv;
    logic [1:0][15:0] e_ad, e_bd;
    logic             p_av, p_bv;
    logic [15:0]      p_ad, p_bd;

    function automatic logic [15:0] lane_mask(input logic [1:0] b);
        return {{8{b[1]}}, {8{b[0]}}};
    endfunction

    task automatic model_reset();
        m_clr_left = DEPTH;
        m_clr_pos  = 0;
        e_busy = 2'b11; e_av = 2'b00; e_bv = 2'b00;
        e_ad = '0; e_bd = '0;
        p_av = 1'b0; p_bv = 1'b0; p_ad = 16'h0000; p_bd = 16'h0000;
    endtask

    task automatic model_step();
        logic        nav, nbv;
        logic [15:0] nad, nbd_old, nbd_new, mk;
        nav = 1'b0; nbv = 1'b0; nad = 16'h0000; nbd_old = 16'h0000; nbd_new = 16'h0000;
        mk = lane_mask(be);
        if (m_clr_left > 0) begin
            m_mem[m_clr_pos] = CV;
            m_clr_pos  = (m_clr_pos + 1) % DEPTH;
            m_clr_left = m_clr_left - 1;
        end else begin
            if (a_rd && !a_wr) begin
                nav = 1'b1;
                nad = m_mem[a_addr];
            end
            if (b_rd) begin
                nbv = 1'b1;
                nbd_old = m_mem[b_addr];
                nbd_new = (a_wr && a_addr == b_addr) ? ((nbd_old & ~mk) | (din & mk)) : nbd_old;
            end
            if (a_wr) m_mem[a_addr] = (m_mem[a_addr] & ~mk) | (din & mk);
            if (clr) begin
                m_clr_left = DEPTH;
                m_clr_pos  = 0;
            end
        end
        e_av[0] = nav; if (nav) e_ad[0] = nad;
        e_bv[0] = nbv; if (nbv) e_bd[0] = nbd_old;
        e_av[1] = p_av; if (p_av) e_ad[1] = p_ad;
        e_bv[1] = p_bv; if (p_bv) e_bd[1] = p_bd;
        p_av = nav; p_ad = nad; p_bv = nbv; p_bd = nbd_new;
        e_busy = {2{m_clr_left > 0}};
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic idle_in();
        a_wr = 1'b0; a_rd = 1'b0; b_rd = 1'b0; clr = 1'b0; be = 2'b00;
    endtask

    task automatic wait_sweep(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy[0] && n < 100);
    endtask

    task automatic read_all(input string nm);
        for (int i = 0; i < DEPTH; i++) begin
            a_rd = 1'b1; a_addr = AW'(i); b_rd = 1'b1; b_addr = AW'(DEPTH - 1 - i);
            tick();
        end
        idle_in();
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            chk({nm, "_a"}, k, a_dout[k], CV);
            chk({nm, "_b"}, k, b_dout[k], CV);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("busy", k, busy[k], e_busy[k]);
                chk("a_valid", k, a_v[k], e_av[k]);
                chk("a_dout", k, a_dout[k], e_ad[k]);
                chk("b_valid", k, b_v[k], e_bv[k]);
                chk("b_dout", k, b_dout[k], e_bd[k]);
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; idle_in(); a_addr = '0; b_addr = '0; din = 16'h0000;
        model_reset();
        chk_en = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 0, busy[0], 1'b1);
        chk("rst_adout", 1, a_dout[1], 16'h0000);
        chk("rst_bvalid", 0, b_v[0], 1'b0);

        rst_n = 1'b1;
        wait_sweep(n);
        chk("sweep_len_rst", 0, n, 16);
        chk("sweep_done", 1, busy[1], 1'b0);
        read_all("after_rst");

        // Byte-lane writes, including an all-lanes-off write
        a_wr = 1'b1; a_addr = 4'd3; din = 16'h1234; be = 2'b11; tick();
        din = 16'hFFEE; be = 2'b01; tick();
        a_wr = 1'b0; a_rd = 1'b1; tick();
        idle_in(); tick(); tick();
        chk("lane_wr", 0, a_dout[0], 16'h12EE);
        chk("lane_wr", 1, a_dout[1], 16'h12EE);
        a_wr = 1'b1; din = 16'h0000; be = 2'b00; tick();
        a_wr = 1'b0; a_rd = 1'b1; tick();
        idle_in(); tick(); tick();
        chk("be_zero", 1, a_dout[1], 16'h12EE);

        // Read-during-write on port B, full and partial lanes
        a_wr = 1'b1; a_addr = 4'd5; din = 16'h0000; be = 2'b11; tick();
        din = 16'hBEEF; b_rd = 1'b1; b_addr = 4'd5; tick();
        idle_in(); tick(); tick();
        chk("rdw_full", 0, b_dout[0], 16'h0000);
        chk("rdw_full", 1, b_dout[1], 16'hBEEF);
        a_wr = 1'b1; a_addr = 4'd6; din = 16'h1234; be = 2'b10; b_rd = 1'b1; b_addr = 4'd6; tick();
        idle_in(); tick(); tick();
        chk("rdw_part", 0, b_dout[0], 16'hA5A5);
        chk("rdw_part", 1, b_dout[1], 16'h12A5);

        // Write and read strobes together: write only
        a_wr = 1'b1; a_rd = 1'b1; a_addr = 4'd7; din = 16'h7777; be = 2'b11; tick();
        idle_in(); tick(); tick();
        chk("wr_rd_hold", 0, a_dout[0], 16'h12EE);
        chk("wr_rd_hold", 1, a_dout[1], 16'h12EE);
        a_rd = 1'b1; a_addr = 4'd7; tick();
        idle_in(); tick(); tick();
        chk("wr_rd_land", 1, a_dout[1], 16'h7777);

        // Read right after write, both ports on the top address
        a_wr = 1'b1; a_addr = 4'd15; din = 16'h0F0F; be = 2'b11; tick();
        a_wr = 1'b0; a_rd = 1'b1; b_rd = 1'b1; b_addr = 4'd15; tick();
        idle_in(); tick(); tick();
        chk("wr_then_rd_a", 0, a_dout[0], 16'h0F0F);
        chk("wr_then_rd_b", 1, b_dout[1], 16'h0F0F);

        // Clear request with port traffic during the sweep and a re-request mid-sweep
        clr = 1'b1; a_rd = 1'b1; a_addr = 4'd8; tick();
        n = 0;
        do begin
            idle_in();
            if (n == 2) begin a_wr = 1'b1; a_addr = 4'd9; din = 16'h9999; be = 2'b11; end
            if (n == 4) begin b_rd = 1'b1; b_addr = 4'd8; a_rd = 1'b1; a_addr = 4'd7; end
            if (n == 8) clr = 1'b1;
            tick();
            n++;
        end while (busy[0] && n < 100);
        idle_in();
        chk("sweep_len_clr", 0, n, 16);
        a_rd = 1'b1; a_addr = 4'd9; tick();
        idle_in(); tick(); tick();
        chk("clr_drop_wr", 0, a_dout[0], 16'hA5A5);
        chk("clr_drop_wr", 1, a_dout[1], 16'hA5A5);

        // Reset in the middle of a sweep
        a_wr = 1'b1; a_addr = 4'd12; din = 16'h1111; be = 2'b11; tick();
        idle_in(); clr = 1'b1; tick();
        idle_in();
        repeat (7) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("midrst_adout", k, a_dout[k], 16'h0000);
            chk("midrst_bdout", k, b_dout[k], 16'h0000);
            chk("midrst_busy", k, busy[k], 1'b1);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        wait_sweep(n);
        chk("sweep_len_rerst", 0, n, 16);
        read_all("after_midrst");

        idle_in(); tick(); tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/salamander_sram_dp.md
Name: salamander_sram_dp

Overview:
Parametrised dual-port synchronous SRAM, the successor to the single-port work RAM used across the board. Port A is a CPU-side read/write port with byte-lane enables; port B is a read-only video/scan port. Adds configurable read latency, a defined read-during-write mode, and a hardware clear sequencer that fills the array with a constant after reset or on request.

Parameters:
AW, 10, address width; depth = 2**AW words
DW, 16, data width; must be a multiple of 8
NBE, DW/8, number of byte lanes (derived, not overridden)
RDLAT, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, 0, B read of an address A writes in the same cycle: 0 = old data, 1 = new merged data
CLR_ON_RST, 1, 1 = run the clear sweep automatically after reset release
CLR_VAL, 0, DW-bit fill value written by the clear sweep

Ports:
i_MCLK  in  1  master clock; all logic on rising edge
i_RST_n  in  1  asynchronous active-low reset
i_CLR  in  1  clear request; sampled only in IDLE
o_BUSY  out  1  high while the clear sweep runs
i_A_ADDR  in  AW  port A address
i_A_DIN  in  DW  port A write data
i_A_BE  in  NBE  port A byte-lane write enables; bit n covers DIN[8n+7:8n]
i_A_WR  in  1  port A write strobe
i_A_RD  in  1  port A read strobe
o_A_DOUT  out  DW  port A read data
o_A_VALID  out  1  one-cycle pulse when o_A_DOUT is updated
i_B_ADDR  in  AW  port B address
i_B_RD  in  1  port B read strobe
o_B_DOUT  out  DW  port B read data
o_B_VALID  out  1  one-cycle pulse when o_B_DOUT is updated

Behaviour:
- Reset (i_RST_n low, asynchronous): o_A_DOUT = o_B_DOUT = 0; o_A_VALID = o_B_VALID = 0; all pipeline stages cleared; clear counter = 0; o_BUSY = CLR_ON_RST. Array contents are not reset.
- FSM states: IDLE, CLEAR. On reset release: CLEAR if CLR_ON_RST=1, else IDLE.
- CLEAR: each cycle, write CLR_VAL to address = counter, all lanes; counter += 1. On the cycle that writes address 2**AW-1, the next state is IDLE. A sweep takes exactly 2**AW cycles. o_BUSY is high for every CLEAR cycle and drops on the first IDLE cycle.
- During CLEAR: port A writes are dropped. Reads on both ports are ignored, VALID stays 0, and DOUT values hold. i_CLR is ignored, so the sweep does not restart. Reset during CLEAR aborts the sweep, then it restarts from address 0 per CLR_ON_RST.
- IDLE + i_CLR=1: enter CLEAR next cycle with counter = 0. Port ops in that same cycle execute normally.
- Port A write (IDLE, i_A_WR=1): lanes with i_A_BE[n]=1 are updated at the clock edge. i_A_BE=0 means no change. i_A_WR and i_A_RD together: the write wins, no read is issued and no VALID is produced.
- Port A read (IDLE, i_A_RD=1, i_A_WR=0): RAM[i_A_ADDR] appears on o_A_DOUT with o_A_VALID=1 exactly RDLAT cycles after the request edge. RDLAT=2 adds one output register stage. DOUT holds its last value when there is no read. Back-to-back reads give one result per cycle.
- Port B read: same timing as port A, independent of A. Both ports may read the same address in the same cycle.
- Read-during-write, B reading the address A writes in the same cycle: RDW_MODE=0 returns the pre-write word. RDW_MODE=1 returns the word with the written lanes replaced by i_A_DIN, unwritten lanes keep old data.
- A read of an address written on the previous cycle always returns the new data.

Test Plan:
- Reset with CLR_ON_RST=1, AW=4, CLR_VAL=16'hA5A5 -> o_BUSY high 16 cycles after release. Then A reads of addresses 0..15 each return 16'hA5A5 with VALID at RDLAT.
- IDLE: A write addr 3 = 16'h1234 with BE=2'b11, then BE=2'b01 with DIN=16'hFFEE -> A read addr 3 returns 16'h12EE. RDLAT=2 case: VALID exactly 2 cycles after RD.
- Same cycle: A writes addr 5 = 16'hBEEF (BE=11, old 16'h0000) while B reads addr 5 -> RDW_MODE=0 gives B 16'h0000; RDW_MODE=1 gives 16'hBEEF.
- Same cycle: i_A_WR and i_A_RD both high -> write lands, o_A_VALID stays 0, o_A_DOUT unchanged.
- IDLE: pulse i_CLR, then issue A write and B read during CLEAR, and re-pulse i_CLR mid-sweep -> write dropped, no B VALID, sweep length still exactly 2**AW cycles.
- Assert i_RST_n low at sweep cycle 7 -> outputs zero immediately. After release, the sweep restarts at address 0 and the full array reads CLR_VAL.
